// File: rtl/mul_dispatch.sv
// Operand range-check and sequencing front end for the 8x8 signed multiplier.
// Resolves zero/overflow locally, otherwise runs the multiplier and returns a tagged product.
module mul_dispatch #(
  parameter int unsigned TIMEOUT = 24
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [15:0] Op_A,
  input  logic [15:0] Op_B,
  input  logic [2:0]  Tag,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Result,
  output logic [2:0]  Result_Tag,
  output logic        Ovf,
  output logic        Err,
  output logic        Mul_Run,
  output logic [7:0]  Mul_A,
  output logic [7:0]  Mul_B,
  input  logic        Mul_Ready,
  input  logic [15:0] Mul_Out
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StFault} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      mul_a_q;
  logic [7:0]      mul_b_q;
  logic [15:0]     result_q;
  logic [2:0]      tag_q;
  logic            ovf_q;
  logic            err_q;

  logic a_zero, b_zero, a_in_range, b_in_range;

  assign a_zero = (Op_A == 16'h0000);
  assign b_zero = (Op_B == 16'h0000);
  // In [-128,127] exactly when bits [15:7] are a pure sign extension.
  assign a_in_range = (&Op_A[15:7]) | ~(|Op_A[15:7]);
  assign b_in_range = (&Op_B[15:7]) | ~(|Op_B[15:7]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mul_a_q  <= 8'h00;
      mul_b_q  <= 8'h00;
      result_q <= 16'h0000;
      tag_q    <= 3'd0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (In_Valid) begin
            tag_q <= Tag;
            if (a_zero || b_zero) begin
              result_q <= 16'h0000;
              ovf_q    <= 1'b0;
              state_q  <= StResp;
            end else if (!(a_in_range && b_in_range)) begin
              result_q <= 16'h0000;
              ovf_q    <= 1'b1;
              state_q  <= StResp;
            end else begin
              mul_a_q <= Op_A[7:0];
              mul_b_q <= Op_B[7:0];
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done pulse on the last allowed cycle still wins over the timeout.
          if (Mul_Ready) begin
            result_q <= Mul_Out;
            ovf_q    <= 1'b0;
            state_q  <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            result_q <= 16'h0000;
            state_q  <= StFault;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (Out_Ready) state_q <= StIdle;
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign In_Ready   = (state_q == StIdle) & ~err_q;
  assign Out_Valid  = (state_q == StResp);
  assign Mul_Run    = (state_q == StIssue);
  assign Mul_A      = mul_a_q;
  assign Mul_B      = mul_b_q;
  assign Result     = result_q;
  assign Result_Tag = tag_q;
  assign Ovf        = ovf_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_mul_dispatch.sv
// Self-checking bench for mul_dispatch: vector table, corner sequences and random requests
// against a multiplier model and an arithmetic reference.
module tb_mul_dispatch;

  localparam int unsigned TIMEOUT = 24;

  logic        Clk;
  logic        Reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Op_A;
  logic [15:0] Op_B;
  logic [2:0]  Tag;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Result;
  logic [2:0]  Result_Tag;
  logic        Ovf;
  logic        Err;
  logic        Mul_Run;
  logic [7:0]  Mul_A;
  logic [7:0]  Mul_B;
  logic        Mul_Ready;
  logic [15:0] Mul_Out;

  mul_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Op_A       (Op_A),
    .Op_B       (Op_B),
    .Tag        (Tag),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Result     (Result),
    .Result_Tag (Result_Tag),
    .Ovf        (Ovf),
    .Err        (Err),
    .Mul_Run    (Mul_Run),
    .Mul_A      (Mul_A),
    .Mul_B      (Mul_B),
    .Mul_Ready  (Mul_Ready),
    .Mul_Out    (Mul_Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Multiplier model: Run in cycle t, Ready with the product in cycle t+18.
  bit          mdl_busy       = 1'b0;
  bit          mdl_respond    = 1'b1;
  int          mdl_cnt        = 0;
  int          last_ready_cyc = -100;
  logic [7:0]  mdl_a          = 8'h00;
  logic [7:0]  mdl_b          = 8'h00;
  logic [15:0] mdl_prod       = 16'h0000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  tag;
    logic [15:0] res;
    logic        ovf;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic       run_seen;
    logic       rst_seen;
    logic [7:0] a_seen;
    logic [7:0] b_seen;
    run_seen = Mul_Run;
    rst_seen = Reset;
    a_seen   = Mul_A;
    b_seen   = Mul_B;
    if (!rst_seen) begin
      if (mdl_busy && !run_seen)
        chk("mul_ab_hold", {16'h0000, a_seen, b_seen}, {16'h0000, mdl_a, mdl_b});
      if (run_seen)
        chk("run_after_halt", 32'(!mdl_busy && (cyc >= last_ready_cyc + 2)), 32'd1);
    end
    @(posedge Clk);
    #1;
    cyc++;
    Mul_Ready = 1'b0;
    Mul_Out   = 16'($urandom);
    if (rst_seen) begin
      mdl_busy = 1'b0;
    end else begin
      if (mdl_busy) begin
        mdl_cnt++;
        if (mdl_cnt == 17 && mdl_respond) begin
          Mul_Ready      = 1'b1;
          Mul_Out        = mdl_prod;
          mdl_busy       = 1'b0;
          last_ready_cyc = cyc;
        end
      end
      if (run_seen) begin
        mdl_busy = 1'b1;
        mdl_cnt  = 0;
        mdl_a    = a_seen;
        mdl_b    = b_seen;
        mdl_prod = 16'(int'($signed(a_seen)) * int'($signed(b_seen)));
      end
    end
  endtask

  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic o, output int lat);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa == 0 || sb == 0) begin
      r = 16'h0000; o = 1'b0; lat = 1;
    end else if (sa < -128 || sa > 127 || sb < -128 || sb > 127) begin
      r = 16'h0000; o = 1'b1; lat = 1;
    end else begin
      r = 16'(sa * sb); o = 1'b0; lat = 20;
    end
  endfunction

  task automatic chk_reset_vals(input string name);
    chk({name, "_ctl"}, 32'({In_Ready, Out_Valid, Mul_Run, Ovf, Err}), 32'b10000);
    chk({name, "_mul_ab"}, 32'({Mul_A, Mul_B}), 32'd0);
    chk({name, "_result"}, 32'({Result_Tag, Result}), 32'd0);
  endtask

  // Offer one request in the current (IDLE) cycle and follow it back to IDLE.
  task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic [2:0] tag,
                        input logic [15:0] er, input logic eo, input int el, input int hold);
    int k;
    int runs;
    int run_k;
    chk("in_ready_c0", 32'(In_Ready), 32'd1);
    In_Valid = 1'b1;
    Op_A     = a;
    Op_B     = b;
    Tag      = tag;
    step();
    In_Valid = 1'b0;
    Op_A     = 16'($urandom);
    Op_B     = 16'($urandom);
    Tag      = 3'($urandom);
    k = 1; runs = 0; run_k = -1;
    while (!Out_Valid && k < 40) begin
      if (Mul_Run) begin
        runs++;
        if (run_k < 0) begin
          run_k = k;
          chk("mul_a_at_run", 32'(Mul_A), 32'(a[7:0]));
          chk("mul_b_at_run", 32'(Mul_B), 32'(b[7:0]));
        end
      end
      chk("in_ready_busy", 32'(In_Ready), 32'd0);
      step();
      k++;
    end
    chk("out_valid_cycle", 32'(k), 32'(el));
    chk("mul_run_count", 32'(runs), (el == 1) ? 32'd0 : 32'd1);
    if (el != 1) chk("mul_run_cycle", 32'(run_k), 32'd1);
    chk("result", 32'(Result), 32'(er));
    chk("result_tag", 32'(Result_Tag), 32'(tag));
    chk("ovf", 32'(Ovf), 32'(eo));
    chk("in_ready_resp", 32'(In_Ready), 32'd0);
    Out_Ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_stable", {10'd0, Out_Valid, In_Ready, Ovf, Result_Tag, Result},
          {10'd0, 1'b1, 1'b0, eo, tag, er});
      if (i == 0) begin
        // Stray done pulse with junk data must not disturb a held result.
        Mul_Ready = 1'b1;
        Mul_Out   = ~er;
      end
      Out_Ready = (i == hold - 1);
    end
    step();
    Out_Ready = 1'b0;
    chk("idle_after_accept", 32'({In_Ready, Out_Valid}), 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] er;
    logic        eo;
    int          el;
    int          va;
    int          vb;
    int          hold;
    int          k;

    // -128*127 = -16256 = 0xC080; 127*-127 = -16129 = 0xC0FF.
    vecs[0] = '{16'h0005, 16'h0003, 3'd2, 16'h000F, 1'b0, 20, 0};
    vecs[1] = '{16'hFF80, 16'hFF80, 3'd1, 16'h4000, 1'b0, 20, 0};
    vecs[2] = '{16'hFF80, 16'h007F, 3'd3, 16'hC080, 1'b0, 20, 0};
    vecs[3] = '{16'hFFFF, 16'h0001, 3'd4, 16'hFFFF, 1'b0, 20, 0};
    vecs[4] = '{16'h0000, 16'h1234, 3'd5, 16'h0000, 1'b0, 1, 0};
    vecs[5] = '{16'h0080, 16'h0002, 3'd6, 16'h0000, 1'b1, 1, 0};
    vecs[6] = '{16'h1234, 16'h0000, 3'd7, 16'h0000, 1'b0, 1, 0};
    vecs[7] = '{16'h007F, 16'hFF81, 3'd1, 16'hC0FF, 1'b0, 20, 10};
    vecs[8] = '{16'hFF7F, 16'h0003, 3'd2, 16'h0000, 1'b1, 1, 10};
    vecs[9] = '{16'h0007, 16'hFFFA, 3'd3, 16'hFFD6, 1'b0, 20, 0};

    Reset = 1'b1; In_Valid = 1'b0; Op_A = 16'h0000; Op_B = 16'h0000; Tag = 3'd0;
    Out_Ready = 1'b0; Mul_Ready = 1'b0; Mul_Out = 16'h0000;
    step();
    step();
    chk_reset_vals("reset");
    Reset = 1'b0;

    for (int i = 0; i < 10; i++)
      do_req(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].ovf, vecs[i].lat,
             vecs[i].hold);

    // Reset in c10 of a multiply, then a clean request.
    In_Valid = 1'b1; Op_A = 16'h0011; Op_B = 16'h0022; Tag = 3'd5;
    step();
    In_Valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    Reset = 1'b1;
    step();
    chk_reset_vals("mid_reset");
    Reset = 1'b0;
    do_req(16'h0011, 16'h0022, 3'd6, 16'h0242, 1'b0, 20, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = 16'h0000; rb = 16'($urandom); end
        1: begin ra = 16'($urandom); rb = 16'($urandom_range(0, 255)); end
        default: begin
          va = int'($urandom_range(0, 255)) - 128;
          vb = int'($urandom_range(0, 255)) - 128;
          ra = 16'(va);
          rb = 16'(vb);
        end
      endcase
      ref_model(ra, rb, er, eo, el);
      hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 4)) : 0;
      do_req(ra, rb, 3'($urandom), er, eo, el, hold);
    end

    // Multiplier never answers: fault appears in cycle c1+TIMEOUT+1 and is sticky.
    mdl_respond = 1'b0;
    chk("to_in_ready_c0", 32'(In_Ready), 32'd1);
    In_Valid = 1'b1; Op_A = 16'h0003; Op_B = 16'h0004; Tag = 3'd1;
    step();
    In_Valid = 1'b0;
    k = 1;
    while (k < int'(TIMEOUT) + 1) begin
      step();
      k++;
    end
    chk("to_err_before", 32'(Err), 32'd0);
    step();
    chk("to_err_set", 32'({Err, In_Ready, Out_Valid}), 32'b100);
    chk("to_result", 32'(Result), 32'd0);
    In_Valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("fault_sticky", 32'({Err, In_Ready, Out_Valid, Mul_Run}), 32'b1000);
    In_Valid = 1'b0;
    Reset = 1'b1;
    step();
    chk_reset_vals("fault_reset");
    Reset = 1'b0;
    mdl_respond = 1'b1;
    do_req(16'h0003, 16'h0004, 3'd1, 16'h000C, 1'b0, 20, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
